// File: rtl/jk_input_conditioner_pkg.sv
// Shared definitions for the J/K switch conditioner: debounce FSM state
// encodings and the debounce counter width derivation.
package jk_input_conditioner_pkg;

    // Gray sequence S_LO -> S_PH -> S_HI -> S_PL: one bit flips per transition.
    localparam logic [1:0] S_LO = 2'b00;
    localparam logic [1:0] S_PH = 2'b01;
    localparam logic [1:0] S_HI = 2'b11;
    localparam logic [1:0] S_PL = 2'b10;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/jk_debounce_ch.sv
// One switch channel: SYNC_STAGES-deep synchronizer followed by a 4-state
// debounce FSM that commits a level only after DEBOUNCE_CYCLES stable cycles.
module jk_debounce_ch
    import jk_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level_out
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign s         = sync_q[SYNC_STAGES-1];
    assign level_out = out_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            S_LO: begin
                if (s) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_PH;
                end else begin
                    cnt_d = '0;
                end
            end
            S_PH: begin
                if (!s) begin
                    cnt_d   = '0;
                    state_d = S_LO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (!s) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_PL;
                end else begin
                    cnt_d = '0;
                end
            end
            S_PL: begin
                if (s) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LO;
                    out_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_LO;
                out_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= S_LO;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: rtl/jk_input_conditioner.sv
// Conditions two raw switch lines into settled J/K levels (a, b) for the JK
// flip-flop, plus a single update strobe when either level changes.
module jk_input_conditioner
    import jk_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic j_raw,
    input  logic k_raw,
    output logic a,
    output logic b,
    output logic ab_upd
);

    logic j_level, k_level;
    logic a_prev_q, a_prev_d;
    logic b_prev_q, b_prev_d;

    jk_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_j (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (j_raw),
        .level_out (j_level)
    );

    jk_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_k (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (k_raw),
        .level_out (k_level)
    );

    // a/b come straight from the channel commit flops, so both bits of a
    // simultaneous commit change on the same edge.
    assign a        = j_level;
    assign b        = k_level;
    assign a_prev_d = j_level;
    assign b_prev_d = k_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
        end else begin
            a_prev_q <= a_prev_d;
            b_prev_q <= b_prev_d;
        end
    end

    // High only in the cycle where a or b differs from its previous-cycle value.
    assign ab_upd = (j_level ^ a_prev_q) | (k_level ^ b_prev_q);

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (6-edge commit latency), 20 ns clock.
module tb_jk_input_conditioner;

    logic clk;
    logic reset_n;
    logic j_raw;
    logic k_raw;
    logic a;
    logic b;
    logic ab_upd;

    int checks = 0;
    int errors = 0;

    localparam int LAT = 6;

    jk_input_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .j_raw   (j_raw),
        .k_raw   (k_raw),
        .a       (a),
        .b       (b),
        .ab_upd  (ab_upd)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects {a,b} to hold old_ab with no strobe for n-1 edges, switch to
    // new_ab with one strobe on edge n, and the strobe to drop on edge n+1.
    task automatic expect_commit(input string tag, input logic [1:0] old_ab,
                                 input logic [1:0] new_ab, input int n);
        for (int i = 1; i < n; i++) begin
            step();
            check({tag, "_hold"}, {a, b, ab_upd}, {old_ab, 1'b0});
        end
        step();
        check({tag, "_commit"}, {a, b, ab_upd}, {new_ab, 1'b1});
        step();
        check({tag, "_after"}, {a, b, ab_upd}, {new_ab, 1'b0});
    endtask

    logic [1:0] seq_v [4];
    logic [1:0] prev_v;
    int         pulses;

    initial begin
        // Reset with both switches already closed.
        reset_n = 1'b0;
        j_raw   = 1'b1;
        k_raw   = 1'b1;
        #1;
        check("reset_state", {a, b, ab_upd}, 3'b000);
        #1;
        reset_n = 1'b1;
        expect_commit("rst_release", 2'b00, 2'b11, LAT);

        j_raw = 1'b0;
        k_raw = 1'b0;
        expect_commit("both_fall", 2'b11, 2'b00, LAT);

        // Clean rise on J only.
        j_raw = 1'b1;
        expect_commit("j_rise", 2'b00, 2'b10, LAT);
        j_raw = 1'b0;
        expect_commit("j_fall", 2'b10, 2'b00, LAT);

        // Bounce: 1,0,1,0 every 2 cycles must not move a.
        for (int i = 0; i < 4; i++) begin
            j_raw = ~i[0];
            step();
            check("bounce_hold", {a, b, ab_upd}, 3'b000);
            step();
            check("bounce_hold", {a, b, ab_upd}, 3'b000);
        end
        j_raw = 1'b1;
        expect_commit("bounce_settle", 2'b00, 2'b10, LAT);

        j_raw = 1'b0;
        expect_commit("j_fall2", 2'b10, 2'b00, LAT);

        // Both switches together: one strobe, never 10 or 01 in between.
        j_raw = 1'b1;
        k_raw = 1'b1;
        expect_commit("jk_same", 2'b00, 2'b11, LAT);

        // Reset one edge before a pending commit.
        j_raw = 1'b0;
        k_raw = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            step();
            check("mid_pending", {a, b, ab_upd}, 3'b110);
        end
        reset_n = 1'b0;
        #1;
        check("mid_reset_now", {a, b, ab_upd}, 3'b000);
        j_raw = 1'b1;
        k_raw = 1'b1;
        step();
        check("mid_reset_hold", {a, b, ab_upd}, 3'b000);
        step();
        check("mid_reset_hold", {a, b, ab_upd}, 3'b000);
        #5;
        reset_n = 1'b1;
        expect_commit("rst_restart", 2'b00, 2'b11, LAT);

        // Reset back to 00, then walk J,K = 00,01,10,11 with 10-cycle holds.
        reset_n = 1'b0;
        j_raw   = 1'b0;
        k_raw   = 1'b0;
        #1;
        check("seq_reset", {a, b, ab_upd}, 3'b000);
        #5;
        reset_n = 1'b1;
        seq_v[0] = 2'b00;
        seq_v[1] = 2'b01;
        seq_v[2] = 2'b10;
        seq_v[3] = 2'b11;
        prev_v   = 2'b00;
        pulses   = 0;
        for (int v = 0; v < 4; v++) begin
            {j_raw, k_raw} = seq_v[v];
            for (int i = 1; i <= 10; i++) begin
                step();
                if (ab_upd) pulses++;
                if (i < LAT)
                    check("seq_lag", {a, b, ab_upd}, {prev_v, 1'b0});
                else if (i == LAT)
                    check("seq_edge", {a, b, ab_upd}, {seq_v[v], seq_v[v] != prev_v});
                else
                    check("seq_steady", {a, b, ab_upd}, {seq_v[v], 1'b0});
            end
            prev_v = seq_v[v];
        end
        check("seq_pulse_count", pulses, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
